// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path types: word/opcode types, halt opcode and the queued fetch entry.
package fetch_unit_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 6;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [OP_W-1:0]   opcode_t;

    localparam opcode_t HALT = 6'b111111;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

endpackage : fetch_unit_pkg

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched entries; flush wins over push and pop, occupancy decides full/empty.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem[wptr] <= wdata;
    end

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, imem request, halt tracking and redirect control
// around a small queue of {instr, pc} entries.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned      WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0,
    parameter int unsigned      DEPTH   = 4,
    parameter opcode_t          HALT_OP = HALT,
    localparam int unsigned     CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic [WORD_W-1:0] imemload,
    input  logic              ihit,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_addr,
    input  logic              stall,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic [WORD_W-1:0] instr_npc,
    output logic [CNT_W-1:0]  count,
    output logic              halted
);

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } entry_t;

    logic [WORD_W-1:0] fpc;
    logic              halt_seen;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    entry_t            wr_entry;
    entry_t            head;

    assign imemaddr    = fpc;
    assign imemREN     = ~halt_seen & ~full & ~redirect & ~halted;
    assign push        = imemREN & ihit;
    assign pop         = ~empty & ~stall & ~redirect;
    assign wr_entry    = '{instr: imemload, pc: fpc};
    assign instr_valid = ~empty;

    // Head fields read as zero whenever the queue is empty.
    assign instr     = instr_valid ? head.instr : '0;
    assign instr_pc  = instr_valid ? head.pc : '0;
    assign instr_npc = instr_valid ? head.pc + WORD_W'(4) : '0;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * WORD_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Redirect restarts fetch at a word-aligned address and re-arms fetch after a halt fetch.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            fpc       <= PC_INIT;
            halt_seen <= 1'b0;
        end else if (redirect) begin
            fpc       <= {redirect_addr[WORD_W-1:2], 2'b00};
            halt_seen <= 1'b0;
        end else if (push) begin
            fpc <= fpc + WORD_W'(4);
            if (imemload[WORD_W-1 -: OP_W] == HALT_OP) halt_seen <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            halted <= 1'b0;
        end else if (pop && (head.instr[WORD_W-1 -: OP_W] == HALT_OP)) begin
            halted <= 1'b1;
        end
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus queues expected head entries, a monitor checks each pop.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        nrst;
    logic        ihit, stall, redirect;
    logic [31:0] raddr;
    logic        imemren;
    logic [31:0] imemaddr, imemload, instr, instr_pc, instr_npc;
    logic        instr_valid, halted;
    logic [2:0]  count;

    logic        w_ihit, w_stall, w_redirect;
    logic        w_imemren;
    logic [31:0] w_imemaddr, w_imemload, w_instr, w_instr_pc, w_instr_npc;
    logic        w_instr_valid, w_halted;
    logic [2:0]  w_count;

    logic        halt_en;
    logic [31:0] halt_addr;
    int          n_checks;
    int          n_fail;
    exp_t        sb[$];

    function automatic logic [31:0] mem_base(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0001;
        if (a == 32'h4) return 32'h2002_0002;
        return {16'h3000, a[15:0]};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (halt_en && a == halt_addr) return 32'hFC00_0000;
        return mem_base(a);
    endfunction

    assign imemload   = (halt_en && imemaddr == halt_addr) ? 32'hFC00_0000 : mem_base(imemaddr);
    assign w_imemload = mem_base(w_imemaddr);

    fetch_unit #(.WORD_W(32), .PC_INIT(32'h0), .DEPTH(4), .HALT_OP(6'b111111)) u0 (
        .CLK(clk), .nRST(nrst), .imemREN(imemren), .imemaddr(imemaddr), .imemload(imemload),
        .ihit(ihit), .redirect(redirect), .redirect_addr(raddr), .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_npc(instr_npc),
        .count(count), .halted(halted)
    );

    fetch_unit #(.WORD_W(32), .PC_INIT(32'hFFFF_FFF8), .DEPTH(4), .HALT_OP(6'b111111)) u1 (
        .CLK(clk), .nRST(nrst), .imemREN(w_imemren), .imemaddr(w_imemaddr), .imemload(w_imemload),
        .ihit(w_ihit), .redirect(w_redirect), .redirect_addr(32'h0), .stall(w_stall),
        .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_npc(w_instr_npc),
        .count(w_count), .halted(w_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the task returns at the following falling edge.
    task automatic cyc(input logic r, input logic ih, input logic st, input logic rd, input logic [31:0] ra);
        @(posedge clk);
        #1;
        nrst = r; ihit = ih; stall = st; redirect = rd; raddr = ra;
        w_ihit = 1'b0; w_stall = 1'b1; w_redirect = 1'b0;
        @(negedge clk);
    endtask

    task automatic cycw(input logic ih, input logic st);
        @(posedge clk);
        #1;
        nrst = 1'b1; ihit = 1'b0; stall = 1'b1; redirect = 1'b0; raddr = '0;
        w_ihit = ih; w_stall = st; w_redirect = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_push(input logic [31:0] a);
        exp_t e;
        e.instr = exp_word(a);
        e.pc    = a;
        sb.push_back(e);
    endtask

    // Monitor: every head the DUT is about to hand to decode must match the oldest expected entry.
    always @(negedge clk) begin
        if (nrst && instr_valid && !stall && !redirect) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got pc %h, expected no valid head", instr_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("head_instr", instr, e.instr);
                chk("head_pc", instr_pc, e.pc);
                chk("head_npc", instr_npc, e.pc + 32'd4);
            end
        end
    end

    initial begin
        n_checks = 0; n_fail = 0;
        halt_en = 1'b0; halt_addr = 32'h8;
        nrst = 1'b0; ihit = 1'b0; stall = 1'b1; redirect = 1'b0; raddr = '0;
        w_ihit = 1'b0; w_stall = 1'b1; w_redirect = 1'b0;

        // Reset state and streaming fetch with no stall
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_npc", instr_npc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 4; i++) expect_push(32'(i * 4));
        cyc(1, 1, 0, 0, 0);
        chk("s1_addr0", imemaddr, 32'd0);
        chk("s1_ren0", 32'(imemren), 32'd1);
        chk("s1_valid0", 32'(instr_valid), 32'd0);
        cyc(1, 1, 0, 0, 0);
        chk("s1_addr1", imemaddr, 32'd4);
        chk("s1_valid1", 32'(instr_valid), 32'd1);
        cyc(1, 1, 0, 0, 0);
        chk("s1_addr2", imemaddr, 32'd8);
        cyc(1, 1, 0, 0, 0);
        chk("s1_addr3", imemaddr, 32'd12);
        chk("s1_count3", 32'(count), 32'd1);
        cyc(1, 0, 0, 0, 0);
        chk("s1_addr4", imemaddr, 32'd16);
        cyc(1, 0, 0, 0, 0);
        chk("s1_drained", 32'(count), 32'd0);
        chk("s1_sb_empty", 32'(sb.size()), 32'd0);

        // Stall fills the queue, fetch stops when full, then drains in order
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) expect_push(32'(i * 4));
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 1, 0, 0);
            chk("s2_fill_count", 32'(count), 32'(i));
            chk("s2_fill_addr", imemaddr, 32'(i * 4));
        end
        chk("s2_full_ren", 32'(imemren), 32'd0);
        cyc(1, 1, 1, 0, 0);
        chk("s2_full_hold", 32'(count), 32'd4);
        cyc(1, 1, 0, 0, 0);
        chk("s2_pop_full_ren", 32'(imemren), 32'd0);
        cyc(1, 1, 0, 0, 0);
        chk("s2_resume_count", 32'(count), 32'd3);
        chk("s2_resume_ren", 32'(imemren), 32'd1);
        chk("s2_resume_addr", imemaddr, 32'd16);
        cyc(1, 0, 0, 0, 0);
        chk("s2_pushpop_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        chk("s2_drained", 32'(count), 32'd0);
        chk("s2_sb_empty", 32'(sb.size()), 32'd0);

        // Redirect with a simultaneous ihit flushes everything and realigns the PC
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 1, 32'h0000_0103);
        chk("s3_pre_count", 32'(count), 32'd3);
        chk("s3_redir_ren", 32'(imemren), 32'd0);
        expect_push(32'h0000_0100);
        cyc(1, 1, 0, 0, 0);
        chk("s3_count", 32'(count), 32'd0);
        chk("s3_valid", 32'(instr_valid), 32'd0);
        chk("s3_addr", imemaddr, 32'h0000_0100);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("s3_sb_empty", 32'(sb.size()), 32'd0);

        // Halt word at pc 8 stops fetch; halted follows its pop and is sticky
        cyc(0, 0, 1, 0, 0);
        halt_en = 1'b1;
        for (int i = 0; i < 3; i++) expect_push(32'(i * 4));
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("s4_ren_at8", 32'(imemren), 32'd1);
        cyc(1, 1, 1, 0, 0);
        chk("s4_ren_stop", 32'(imemren), 32'd0);
        chk("s4_count", 32'(count), 32'd3);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("s4_not_yet", 32'(halted), 32'd0);
        cyc(1, 1, 0, 0, 0);
        chk("s4_halted", 32'(halted), 32'd1);
        chk("s4_ren_halted", 32'(imemren), 32'd0);
        cyc(1, 1, 0, 1, 32'h40);
        chk("s4_halted_redir", 32'(halted), 32'd1);
        cyc(1, 1, 0, 0, 0);
        chk("s4_halted_sticky", 32'(halted), 32'd1);
        chk("s4_ren_sticky", 32'(imemren), 32'd0);
        chk("s4_addr_redir", imemaddr, 32'h40);
        cyc(1, 0, 0, 1, 0);
        chk("s4_halted_end", 32'(halted), 32'd1);
        chk("s4_sb_empty", 32'(sb.size()), 32'd0);
        halt_en = 1'b0;

        // Reset mid-fetch discards the queue and the ihit of the reset cycle
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("s6_pre_count", 32'(count), 32'd2);
        cyc(1, 0, 1, 0, 0);
        chk("s6_count", 32'(count), 32'd0);
        chk("s6_halted", 32'(halted), 32'd0);
        chk("s6_addr", imemaddr, 32'd0);
        chk("s6_valid", 32'(instr_valid), 32'd0);

        // PC wrap at the top of the address space on the second instance
        cyc(0, 0, 1, 0, 0);
        cycw(1, 1);
        chk("w_addr0", w_imemaddr, 32'hFFFF_FFF8);
        cycw(1, 1);
        chk("w_addr1", w_imemaddr, 32'hFFFF_FFFC);
        chk("w_pc0", w_instr_pc, 32'hFFFF_FFF8);
        chk("w_npc0", w_instr_npc, 32'hFFFF_FFFC);
        cycw(1, 1);
        chk("w_addr2", w_imemaddr, 32'h0000_0000);
        cycw(0, 0);
        chk("w_count", 32'(w_count), 32'd3);
        chk("w_head0", w_instr_pc, 32'hFFFF_FFF8);
        cycw(0, 0);
        chk("w_head1", w_instr_pc, 32'hFFFF_FFFC);
        chk("w_npc1", w_instr_npc, 32'h0000_0000);
        chk("w_instr1", w_instr, mem_base(32'hFFFF_FFFC));
        cycw(0, 0);
        chk("w_head2", w_instr_pc, 32'h0000_0000);
        chk("w_instr2", w_instr, 32'h2001_0001);
        cycw(0, 0);
        chk("w_empty", 32'(w_instr_valid), 32'd0);

        cyc(1, 0, 1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end; successor to the single-register PC/halt-latch logic inside the datapath.
- Owns the fetch PC and issues instruction-memory reads via the datapath_cache_if imem signals.
- Buffers fetched words with their PCs in a DEPTH-entry queue so decode can stall without blocking fetch.
- Supports redirect/flush for branch, jump and jr, and latches halt when a halt instruction is consumed.

Parameters:
- PC_INIT, 0, fetch PC value after reset.
- WORD_W, 32, instruction and address width.
- DEPTH, 4, fetch queue entries; power of two, at least 2.
- HALT_OP, 6'b111111, opcode (bits [WORD_W-1:WORD_W-6]) that identifies halt.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  synchronous active-low reset, sampled on the rising edge of CLK.
- imemREN  out  1  instruction read request.
- imemaddr  out  WORD_W  fetch PC.
- imemload  in  WORD_W  instruction data; valid when ihit=1.
- ihit  in  1  read completes this cycle.
- redirect  in  1  flush and restart fetch.
- redirect_addr  in  WORD_W  new fetch PC.
- stall  in  1  decode cannot accept the head instruction this cycle.
- instr_valid  out  1  queue head valid.
- instr  out  WORD_W  head instruction.
- instr_pc  out  WORD_W  PC of the head instruction.
- instr_npc  out  WORD_W  instr_pc+4, modulo 2^WORD_W.
- count  out  $clog2(DEPTH+1)  queue occupancy.
- halted  out  1  sticky: halt instruction consumed.

Behaviour:
- Reset (nRST=0 at a rising edge): fpc=PC_INIT; queue empty; count=0; halt_seen=0; halted=0. Hence instr_valid=0, instr/instr_pc/instr_npc=0, imemaddr=PC_INIT. A reset mid-fetch discards everything, including an ihit in that same cycle.
- imemaddr = fpc, combinational.
- imemREN = !halt_seen & !full & !redirect & !halted, combinational.
- Push: when imemREN & ihit, enqueue {imemload, fpc} and set fpc <= fpc+4, wrapping modulo 2^WORD_W.
  - If the pushed word's opcode == HALT_OP, set halt_seen <= 1. Fetch then stops; the halt word itself is queued.
- Pop: when instr_valid & !stall & !redirect. The head is removed at the edge.
  - If the popped word's opcode == HALT_OP, set halted <= 1. It stays set until reset.
- Latency: ihit in cycle N gives instr_valid in cycle N+1 at the earliest. There is no bypass, even when the queue is empty.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Full (count==DEPTH): imemREN=0, no push. A pop in that cycle frees one slot for the next cycle.
- Empty: instr_valid=0; stall is ignored.
- Redirect (highest priority):
  - Queue cleared, so count=0 next cycle.
  - fpc <= {redirect_addr[WORD_W-1:2], 2'b00}.
  - halt_seen <= 0.
  - Any ihit and any pop in that cycle are discarded.
  - halted is not affected.
- halted=1: imemREN=0 permanently; queue contents are frozen except for pops.
- Pointers: log2(DEPTH) bits, natural wrap at DEPTH. Full vs empty is decided by count.

Decomposition:
- cpu_types_pkg gains:
  - HALT opcode constant (opcode_t value).
  - fetch_entry_t packed struct {word_t instr; word_t pc}.
  - When WORD_W is not 32, the struct is generated locally from WORD_W.
- Sub-module fetch_fifo: synchronous FIFO with DEPTH and WIDTH parameters; ports push, pop, flush, wdata, rdata, full, empty, count. Flush has priority over push and pop.
- fetch_unit contains PC, halt and control logic only.

Test Plan:
- Reset then ihit held 1, stall=0, memory returns 32'h2001_0001 at address 0 and 32'h2002_0002 at address 4.
  → imemaddr sequence 0,4,8,…
  → instr_valid rises one cycle after the first ihit with instr=32'h2001_0001, instr_pc=0, instr_npc=4.
- stall=1 with ihit=1 continuously, DEPTH=4.
  → count climbs 1..4; imemREN drops at count==4 with imemaddr=16.
  → Release stall: head pc=0, 4, 8, 12 in order; fetch resumes at 16.
- Queue holding pcs 0,4,8, then redirect=1, redirect_addr=32'h0000_0103, with ihit=1 in the same cycle.
  → Next cycle: count=0, instr_valid=0, imemaddr=32'h0000_0100.
  → The ihit word is not queued.
- Word 32'hFC00_0000 fetched at pc 8.
  → imemREN=0 from the next cycle.
  → halted=1 the cycle after that word is popped; it stays 1 while redirect and ihit toggle.
- PC_INIT=32'hFFFF_FFF8, ihit=1.
  → imemaddr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  → instr_npc for pc FFFF_FFFC is 0.
- Queue count=2 mid-fetch, nRST=0 for one edge.
  → count=0, halted=0, imemaddr=PC_INIT.
  → The ihit in the reset cycle is not queued.
